// File: rtl/arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } arb_port_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Merges the cpu fetch and data ports onto a single fixed-latency memory bus,
// one transaction at a time, data first with a bounded streak so fetch always progresses.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  // instruction fetch port
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory bus
  output logic [31:0]       address,
  output logic [DATA_W-1:0] to_memory,
  output logic              write,
  input  logic [DATA_W-1:0] from_memory
);

  localparam int unsigned CntW    = $clog2(MEM_LATENCY + 1);
  localparam int unsigned StreakW = $clog2(MAX_D_STREAK + 1);
  localparam logic [CntW-1:0]    CntLoad   = CntW'(MEM_LATENCY - 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);

  arb_state_t          state_q, state_d;
  arb_port_t           port_q, port_d;
  logic                we_q, we_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic [31:0]         address_q, address_d;
  logic [DATA_W-1:0]   to_memory_q, to_memory_d;
  logic                write_q, write_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic grant_i, grant_d, streak_full;

  // Grants are only offered in IDLE; a full streak hands the slot to a waiting fetch.
  always_comb begin
    streak_full = (streak_q == StreakMax);
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    if (reset && (state_q == IDLE)) begin
      grant_d = d_req && !(if_req && streak_full);
      grant_i = if_req && !grant_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    address_d   = address_q;
    to_memory_d = to_memory_q;
    write_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          port_d    = PORT_D;
          we_d      = d_we;
          address_d = word_align(d_addr);
          if (d_we) begin
            to_memory_d = d_wdata;
            write_d     = 1'b1;
          end
          streak_d = !if_req ? '0 : (streak_full ? streak_q : streak_q + 1'b1);
          state_d  = ISSUE;
        end else if (grant_i) begin
          port_d    = PORT_I;
          we_d      = 1'b0;
          address_d = word_align(if_addr);
          streak_d  = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // Writes complete without waiting on the memory.
        if (we_q) begin
          d_rvalid_d = 1'b1;
          d_rdata_d  = '0;
          state_d    = RESP;
        end else begin
          cnt_d   = CntLoad;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (port_q == PORT_D) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = from_memory;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = from_memory;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      port_q      <= PORT_I;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      streak_q    <= '0;
      address_q   <= '0;
      to_memory_q <= '0;
      write_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      address_q   <= address_d;
      to_memory_q <= to_memory_d;
      write_q     <= write_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_ready  = grant_i;
  assign d_ready   = grant_d;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign address   = address_q;
  assign to_memory = to_memory_q;
  assign write     = write_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance at latency 1, one at latency 3, random traffic.
module tb_mem_arbiter;

  localparam int MaxStreak = 4;

  typedef struct {
    int          k;
    bit          p;
    int          due;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst       [2];
  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic        if_ready  [2];
  logic        if_rvalid [2];
  logic [31:0] if_rdata  [2];
  logic        d_req     [2];
  logic        d_we      [2];
  logic [31:0] d_addr    [2];
  logic [31:0] d_wdata   [2];
  logic        d_ready   [2];
  logic        d_rvalid  [2];
  logic [31:0] d_rdata   [2];
  logic [31:0] address   [2];
  logic [31:0] to_memory [2];
  logic        write     [2];
  logic [31:0] from_memory [2];

  int checks;
  int errors;
  int cyc = 0;

  exp_t        sb [$];
  logic [31:0] env_mem [logic [30:0]];
  logic [31:0] ref_mem [logic [30:0]];
  logic [31:0] hist [2][4];

  // Reference model state
  bit          started  [2];
  int          streak   [2];
  int          acc_cyc  [2];
  int          free_cyc [2];
  bit          cur_we   [2];
  logic [31:0] exp_addr [2];
  logic [31:0] exp_tom  [2];
  logic [31:0] hold     [2][2];

  mem_arbiter #(.MEM_LATENCY(1), .MAX_D_STREAK(MaxStreak), .DATA_W(32)) u_dut_l1 (
    .clk(clk), .reset(rst[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ready(if_ready[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_ready(d_ready[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .address(address[0]), .to_memory(to_memory[0]), .write(write[0]),
    .from_memory(from_memory[0])
  );

  mem_arbiter #(.MEM_LATENCY(3), .MAX_D_STREAK(MaxStreak), .DATA_W(32)) u_dut_l3 (
    .clk(clk), .reset(rst[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ready(if_ready[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_ready(d_ready[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .address(address[1]), .to_memory(to_memory[1]), .write(write[1]),
    .from_memory(from_memory[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [30:0] key(int k, logic [31:0] a);
    return {k[0], a[31:2]};
  endfunction

  function automatic logic [31:0] dflt(logic [30:0] kk);
    return {1'b0, kk} * 32'h9E37_79B1;
  endfunction

  function automatic logic [31:0] env_rd(logic [30:0] kk);
    if (env_mem.exists(kk)) return env_mem[kk];
    return dflt(kk);
  endfunction

  function automatic logic [31:0] ref_rd(logic [30:0] kk);
    if (ref_mem.exists(kk)) return ref_mem[kk];
    return dflt(kk);
  endfunction

  function automatic logic [31:0] rnd_addr();
    return 32'($urandom_range(0, 255));
  endfunction

  task automatic chk(int k, string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s at cycle %0d: got %h expected %h", k, name, cyc, act, exp);
    end
  endtask

  task automatic reset_model(int k);
    streak[k]   = 0;
    acc_cyc[k]  = -100;
    free_cyc[k] = 0;
    cur_we[k]   = 1'b0;
    exp_addr[k] = '0;
    exp_tom[k]  = '0;
    hold[k][0]  = '0;
    hold[k][1]  = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].k == k) sb.delete(i);
    end
  endtask

  task automatic accept(int k, bit is_d, logic we, logic [31:0] a, logic [31:0] wd);
    exp_t e;
    e.k         = k;
    e.p         = is_d;
    acc_cyc[k]  = cyc;
    cur_we[k]   = we;
    exp_addr[k] = a & 32'hFFFF_FFFC;
    if (we) begin
      ref_mem[key(k, a)] = wd;
      exp_tom[k]  = wd;
      e.data      = '0;
      e.due       = cyc + 2;
      free_cyc[k] = cyc + 3;
    end else begin
      e.data      = ref_rd(key(k, a));
      e.due       = cyc + lat(k) + 2;
      free_cyc[k] = e.due + 1;
    end
    if (is_d) streak[k] = if_req[k] ? ((streak[k] < MaxStreak) ? streak[k] + 1 : streak[k]) : 0;
    else      streak[k] = 0;
    sb.push_back(e);
  endtask

  task automatic monitor(int k);
    logic        ei, ed, rv, exp_v;
    logic [31:0] rd;
    int          idx;
    string       nv, nd;
    if (started[k]) begin
      ei = 1'b0;
      ed = 1'b0;
      if (rst[k] && (cyc >= free_cyc[k])) begin
        ed = d_req[k] && !(if_req[k] && (streak[k] == MaxStreak));
        ei = if_req[k] && !ed;
      end
      chk(k, "if_ready", 32'(if_ready[k]), 32'(ei));
      chk(k, "d_ready", 32'(d_ready[k]), 32'(ed));
      chk(k, "address", address[k], exp_addr[k]);
      chk(k, "to_memory", to_memory[k], exp_tom[k]);
      chk(k, "write", 32'(write[k]), 32'((cyc == acc_cyc[k] + 1) && cur_we[k]));
      for (int p = 0; p < 2; p++) begin
        rv  = (p == 1) ? d_rvalid[k] : if_rvalid[k];
        rd  = (p == 1) ? d_rdata[k] : if_rdata[k];
        nv  = (p == 1) ? "d_rvalid" : "if_rvalid";
        nd  = (p == 1) ? "d_rdata" : "if_rdata";
        idx = -1;
        foreach (sb[i]) begin
          if (sb[i].k == k && sb[i].p == p[0] && sb[i].due <= cyc) idx = i;
        end
        exp_v = (idx >= 0) && (sb[idx].due == cyc);
        chk(k, nv, 32'(rv), 32'(exp_v));
        if (idx >= 0) begin
          hold[k][p] = sb[idx].data;
          sb.delete(idx);
        end
        chk(k, nd, rd, hold[k][p]);
      end
    end
    if (!rst[k]) begin
      reset_model(k);
      started[k] = 1'b1;
    end else if (started[k]) begin
      if (d_req[k] && d_ready[k]) accept(k, 1'b1, d_we[k], d_addr[k], d_wdata[k]);
      else if (if_req[k] && if_ready[k]) accept(k, 1'b0, 1'b0, if_addr[k], '0);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) monitor(k);
  end

  // Fixed-latency memory: returns the word addressed MEM_LATENCY cycles earlier.
  initial begin
    logic [31:0] neg_addr [2];
    for (int k = 0; k < 2; k++) begin
      neg_addr[k]    = '0;
      from_memory[k] = '0;
      for (int j = 0; j < 4; j++) hist[k][j] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        neg_addr[k] = address[k];
        if (write[k] === 1'b1) env_mem[key(k, address[k])] = to_memory[k];
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        for (int j = 3; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0]     = neg_addr[k];
        from_memory[k] = env_rd(key(k, hist[k][lat(k)-1]));
      end
    end
  end

  task automatic wait_grant(int k, bit is_d);
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = is_d ? (d_ready[k] === 1'b1) : (if_ready[k] === 1'b1);
    end
    if (!ok) chk(k, is_d ? "d_grant_timeout" : "if_grant_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic gap(int k, int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_d(int k, logic we, logic [31:0] a, logic [31:0] wd);
    d_req[k]   = 1'b1;
    d_we[k]    = we;
    d_addr[k]  = a;
    d_wdata[k] = wd;
    wait_grant(k, 1'b1);
    // Scramble fields after accept; the arbiter must have latched them.
    d_req[k]   = 1'b0;
    d_we[k]    = 1'($urandom);
    d_addr[k]  = $urandom;
    d_wdata[k] = $urandom;
  endtask

  task automatic do_if(int k, logic [31:0] a);
    if_req[k]  = 1'b1;
    if_addr[k] = a;
    wait_grant(k, 1'b0);
    if_req[k]  = 1'b0;
    if_addr[k] = $urandom;
  endtask

  task automatic run_all(int k);
    rst[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst[k] = 1'b1;
    env_mem[key(k, 32'h100)] = 32'hE3A0_0001;
    ref_mem[key(k, 32'h100)] = 32'hE3A0_0001;

    do_if(k, 32'h103);
    gap(k, 2);
    do_d(k, 1'b1, 32'h200, 32'hDEAD_BEEF);
    do_d(k, 1'b0, 32'h202, 32'h0);

    // Both ports saturated: data streak must yield to fetch.
    fork
      for (int i = 0; i < 12; i++) do_d(k, 1'($urandom), rnd_addr(), $urandom);
      for (int i = 0; i < 3; i++) do_if(k, rnd_addr());
    join

    fork
      for (int i = 0; i < 25; i++) begin
        gap(k, $urandom_range(0, 4));
        do_d(k, 1'($urandom), rnd_addr(), $urandom);
      end
      for (int i = 0; i < 25; i++) begin
        gap(k, $urandom_range(0, 4));
        do_if(k, rnd_addr());
      end
    join

    // Reset while the read sits in WAIT: the response must never appear.
    d_req[k]  = 1'b1;
    d_we[k]   = 1'b0;
    d_addr[k] = 32'h44;
    wait_grant(k, 1'b1);
    d_req[k]  = 1'b0;
    gap(k, 1);
    rst[k] = 1'b0;
    gap(k, 1);
    rst[k] = 1'b1;
    gap(k, 8);
    do_d(k, 1'b0, 32'h44, 32'h0);
    do_if(k, 32'h100);
    gap(k, 6);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int k = 0; k < 2; k++) begin
      rst[k]     = 1'b0;
      if_req[k]  = 1'b0;
      if_addr[k] = '0;
      d_req[k]   = 1'b0;
      d_we[k]    = 1'b0;
      d_addr[k]  = '0;
      d_wdata[k] = '0;
      started[k] = 1'b0;
      streak[k]   = 0;
      acc_cyc[k]  = -100;
      free_cyc[k] = 0;
      cur_we[k]   = 1'b0;
      exp_addr[k] = '0;
      exp_tom[k]  = '0;
      hold[k][0]  = '0;
      hold[k][1]  = '0;
    end
    fork
      run_all(0);
      run_all(1);
    join
    repeat (10) @(posedge clk);
    chk(0, "scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
